speech_number_sequencer: RTL and testbench

Programmable, parametrised number-to-speech sequencer for the audio path. It accepts a number (0..MAX_NUM) on a start pulse and decomposes it into spoken clips: hundreds digit, "hundred", tens word or teen/unit word, unit word, and an optional "beats per minute" suffix. It issues each clip's flash start/stop address to the audio playback engine over a valid/ready handshake and waits for playback completion before issuing the next clip. Clip addresses live in a run-time writable table rather than being fixed in logic.

---
 rtl/speech_number_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_speech_number_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/speech_number_sequencer.sv
// Number-to-speech sequencer: splits a number into spoken clips by iterative
// subtraction and hands each clip's flash range to the playback engine.
module speech_number_sequencer #(
  parameter int ADDR_W  = 32,
  parameter int NUM_W   = 10,
  parameter int MAX_NUM = 999
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [NUM_W-1:0]  number,
  input  logic              suffix_en,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              play_valid,
  output logic [ADDR_W-1:0] play_start,
  output logic [ADDR_W-1:0] play_stop,
  input  logic              play_ready,
  input  logic              play_done,
  input  logic              tbl_we,
  input  logic [4:0]        tbl_idx,
  input  logic [ADDR_W-1:0] tbl_start,
  input  logic [ADDR_W-1:0] tbl_stop
);

  typedef enum logic [2:0] {IDLE, DIV_H, DIV_T, BUILD, FETCH, PRESENT, WAIT} state_t;

  localparam logic [NUM_W-1:0] MAX_V   = NUM_W'(MAX_NUM);
  localparam logic [NUM_W-1:0] HUNDRED = NUM_W'(100);
  localparam logic [NUM_W-1:0] TEN     = NUM_W'(10);

  state_t            state, state_nxt;
  logic [NUM_W-1:0]  rem, rem_nxt;
  logic [3:0]        h, h_nxt, t, t_nxt;
  logic              sfx, sfx_nxt;
  logic [24:0]       lst, lst_nxt;
  logic [2:0]        len, len_nxt;
  logic              busy_nxt, done_nxt, err_nxt, pv_nxt, adv;
  logic [ADDR_W-1:0] ps_nxt, pe_nxt;
  logic [ADDR_W-1:0] tab_start [32];
  logic [ADDR_W-1:0] tab_stop  [32];
  logic [4:0]        cur_clip;

  // Clip list packed five bits per entry, first clip in the low bits; returns {count, list}.
  function automatic logic [27:0] build_list(input logic [3:0] hd, input logic [3:0] td,
                                             input logic [3:0] ud, input logic sx);
    logic [24:0] l;
    int          n;
    l = '0;
    n = 0;
    if (hd != 4'd0) begin
      l = l | (25'({1'b0, hd}) << (5 * n)); n++;
      l = l | (25'(5'd28) << (5 * n));      n++;
    end
    if (td >= 4'd2) begin
      l = l | (25'(5'd18 + {1'b0, td}) << (5 * n)); n++;
      if (ud != 4'd0) begin
        l = l | (25'({1'b0, ud}) << (5 * n)); n++;
      end
    end else if (td == 4'd1) begin
      l = l | (25'(5'd10 + {1'b0, ud}) << (5 * n)); n++;
    end else if (ud != 4'd0) begin
      l = l | (25'({1'b0, ud}) << (5 * n)); n++;
    end
    if (hd == 4'd0 && td == 4'd0 && ud == 4'd0) begin
      l = l | (25'(5'd30) << (5 * n)); n++;
    end
    if (sx) begin
      l = l | (25'(5'd29) << (5 * n)); n++;
    end
    return {3'(n), l};
  endfunction

  assign cur_clip = lst[4:0];

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    h_nxt     = h;
    t_nxt     = t;
    sfx_nxt   = sfx;
    lst_nxt   = lst;
    len_nxt   = len;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    pv_nxt    = play_valid;
    ps_nxt    = play_start;
    pe_nxt    = play_stop;
    adv       = 1'b0;
    if (abort && state != IDLE) begin
      state_nxt = IDLE;
      busy_nxt  = 1'b0;
      pv_nxt    = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (number > MAX_V) begin
              err_nxt = 1'b1;
            end else begin
              rem_nxt   = number;
              h_nxt     = 4'd0;
              t_nxt     = 4'd0;
              sfx_nxt   = suffix_en;
              busy_nxt  = 1'b1;
              state_nxt = DIV_H;
            end
          end
        end
        DIV_H: begin
          if (rem >= HUNDRED) begin
            rem_nxt = rem - HUNDRED;
            h_nxt   = h + 4'd1;
          end else begin
            state_nxt = DIV_T;
          end
        end
        DIV_T: begin
          if (rem >= TEN) begin
            rem_nxt = rem - TEN;
            t_nxt   = t + 4'd1;
          end else begin
            state_nxt = BUILD;
          end
        end
        BUILD: begin
          {len_nxt, lst_nxt} = build_list(h, t, rem[3:0], sfx);
          state_nxt          = FETCH;
        end
        FETCH: begin
          ps_nxt    = tab_start[cur_clip];
          pe_nxt    = tab_stop[cur_clip];
          pv_nxt    = (tab_start[cur_clip] != tab_stop[cur_clip]);
          state_nxt = PRESENT;
        end
        PRESENT: begin
          // play_valid low here means the fetched entry was unprogrammed
          if (!play_valid) begin
            adv = 1'b1;
          end else if (play_ready) begin
            pv_nxt    = 1'b0;
            state_nxt = WAIT;
          end
        end
        WAIT: begin
          if (play_done) adv = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
      if (adv) begin
        if (len <= 3'd1) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
        end else begin
          len_nxt   = len - 3'd1;
          lst_nxt   = lst >> 5;
          state_nxt = FETCH;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      play_valid <= 1'b0;
      play_start <= '0;
      play_stop  <= '0;
    end else begin
      state      <= state_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      err        <= err_nxt;
      play_valid <= pv_nxt;
      play_start <= ps_nxt;
      play_stop  <= pe_nxt;
    end
    rem <= rem_nxt;
    h   <= h_nxt;
    t   <= t_nxt;
    sfx <= sfx_nxt;
    lst <= lst_nxt;
    len <= len_nxt;
  end

  // Writes land after this cycle's fetch, so a same-index fetch sees the old entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        tab_start[i] <= '0;
        tab_stop[i]  <= '0;
      end
    end else if (tbl_we) begin
      tab_start[tbl_idx] <= tbl_start;
      tab_stop[tbl_idx]  <= tbl_stop;
    end
  end

endmodule

// File: tb/tb_speech_number_sequencer.sv
// Randomized bench for speech_number_sequencer with a behavioural clip-list and timing model.
module tb_speech_number_sequencer;
  localparam int ADDR_W  = 32;
  localparam int NUM_W   = 10;
  localparam int MAX_NUM = 999;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [NUM_W-1:0]  number = '0;
  logic              suffix_en = 1'b0;
  logic              abort = 1'b0;
  logic              busy, done, err, play_valid;
  logic [ADDR_W-1:0] play_start, play_stop;
  logic              play_ready = 1'b0;
  logic              play_done = 1'b0;
  logic              tbl_we = 1'b0;
  logic [4:0]        tbl_idx = '0;
  logic [ADDR_W-1:0] tbl_start = '0;
  logic [ADDR_W-1:0] tbl_stop = '0;

  speech_number_sequencer #(.ADDR_W(ADDR_W), .NUM_W(NUM_W), .MAX_NUM(MAX_NUM)) dut (
    .clk(clk), .reset(reset), .start(start), .number(number), .suffix_en(suffix_en),
    .abort(abort), .busy(busy), .done(done), .err(err), .play_valid(play_valid),
    .play_start(play_start), .play_stop(play_stop), .play_ready(play_ready),
    .play_done(play_done), .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_start(tbl_start),
    .tbl_stop(tbl_stop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] m_start [32];
  logic [31:0] m_stop  [32];
  int          exp_clips[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tbl_write(input int idx, input logic [31:0] s, input logic [31:0] e);
    tbl_we = 1'b1; tbl_idx = 5'(idx); tbl_start = s; tbl_stop = e;
    step();
    tbl_we = 1'b0;
    m_start[idx] = s;
    m_stop[idx]  = e;
  endtask

  // Spoken-word decomposition using ordinary decimal arithmetic.
  function automatic void fill_clips(input int num, input bit sx);
    int hd, td, ud;
    hd = num / 100;
    td = (num / 10) % 10;
    ud = num % 10;
    exp_clips.delete();
    if (hd > 0) begin exp_clips.push_back(hd); exp_clips.push_back(28); end
    if (td >= 2) begin
      exp_clips.push_back(18 + td);
      if (ud > 0) exp_clips.push_back(ud);
    end else if (td == 1) exp_clips.push_back(10 + td * 0 + ud);
    else if (ud > 0) exp_clips.push_back(ud);
    if (num == 0) exp_clips.push_back(30);
    if (sx) exp_clips.push_back(29);
  endfunction

  // Runs one sequence; abort_at >= 0 aborts in WAIT of that issued clip (0-based).
  task automatic run_seq(input int num, input bit sx, input int rdy_dly, input int done_dly,
                         input int abort_at);
    int e0, r, k, lim, issued, c;
    fill_clips(num, sx);
    number = NUM_W'(num); suffix_en = sx; start = 1'b1;
    step();
    start = 1'b0;
    e0 = cyc;
    chk("busy_rise", busy, 1);
    r = e0 + num / 100 + (num / 10) % 10 + 3;
    k = 0;
    issued = 0;
    foreach (exp_clips[j]) begin
      c = exp_clips[j];
      if (m_start[c] == m_stop[c]) begin
        k++;
        continue;
      end
      lim = cyc + 200;
      while (play_valid !== 1'b1 && cyc < lim) step();
      chk($sformatf("valid_edge_c%0d", c), cyc - e0, r + 1 + 2 * k - e0);
      chk($sformatf("start_c%0d", c), play_start, m_start[c]);
      chk($sformatf("stop_c%0d", c), play_stop, m_stop[c]);
      for (int w = 0; w < rdy_dly; w++) begin
        step();
        chk("hold_valid", play_valid, 1);
        chk("hold_addr", {play_start, play_stop}, {m_start[c], m_stop[c]});
      end
      play_ready = 1'b1;
      step();
      play_ready = 1'b0;
      chk("accept_drop", play_valid, 0);
      for (int w = 1; w < done_dly; w++) step();
      chk("no_clip_before_done", play_valid, 0);
      if (issued == abort_at) begin
        abort = 1'b1; play_done = 1'b1; start = 1'b1; number = NUM_W'(5);
        step();
        abort = 1'b0; play_done = 1'b0; start = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_valid", play_valid, 0);
        chk("abort_done", done, 0);
        step();
        chk("abort_start_dropped", busy, 0);
        chk("abort_no_done", done, 0);
        return;
      end
      play_done = 1'b1;
      step();
      play_done = 1'b0;
      r = cyc;
      k = 0;
      issued++;
    end
    lim = cyc + 200;
    while (done !== 1'b1 && cyc < lim) step();
    chk($sformatf("done_edge_n%0d", num), cyc - e0, r + 2 * k - e0);
    chk("busy_fall", busy, 0);
    step();
    chk("done_pulse", done, 0);
  endtask

  task automatic run_err(input int num);
    number = NUM_W'(num); suffix_en = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    chk("err_pulse", err, 1);
    chk("err_busy", busy, 0);
    chk("err_valid", play_valid, 0);
    step();
    chk("err_clear", err, 0);
    chk("err_busy2", busy, 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin m_start[i] = '0; m_stop[i] = '0; end
    repeat (3) step();
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_valid", play_valid, 0);
    chk("rst_addr", {play_start, play_stop}, 64'd0);
    // Empty table after reset: every clip is skipped.
    run_seq(5, 1'b0, 0, 1, -1);

    for (int i = 1; i <= 30; i++)
      tbl_write(i, 32'h1000 * i, 32'h1000 * i + 32'h800 + i);
    run_seq(147, 1'b1, 0, 5, -1);
    run_seq(0, 1'b0, 0, 5, -1);
    tbl_write(13, 32'h0, 32'h0);
    run_seq(13, 1'b1, 0, 5, -1);
    tbl_write(13, 32'hd000, 32'hd80d);
    run_err(1000);
    run_seq(90, 1'b0, 6, 5, -1);
    run_seq(147, 1'b1, 0, 3, 1);
    run_seq(147, 1'b1, 1, 2, -1);

    for (int it = 0; it < 30; it++) begin
      if (it % 6 == 0) begin
        for (int i = 1; i <= 30; i++) begin
          logic [31:0] s;
          s = $urandom;
          if ($urandom_range(0, 4) == 0) tbl_write(i, s, s);
          else tbl_write(i, s, s + 32'd1 + 32'($urandom_range(0, 4095)));
        end
      end
      if ($urandom_range(0, 9) == 0) run_err($urandom_range(1000, 1023));
      else run_seq($urandom_range(0, 999), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3), $urandom_range(1, 4), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: sim time limit reached");
    $fatal(1);
  end

endmodule
